// File: rtl/glitch_pkg.sv
// Shared types and field widths for the glitch sequencer and its down-counter.
package glitch_pkg;

   localparam int DELAY_W   = 16;
   localparam int WIDTH_W   = 8;
   localparam int NUM_W     = 8;
   localparam int SPACING_W = 16;
   localparam int RSTLEN_W  = 16;
   localparam int CNT_W     = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRST,
      ST_DELAY,
      ST_PULSE,
      ST_SPACE,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [DELAY_W-1:0]   delay;
      logic [WIDTH_W-1:0]   width;
      logic [NUM_W-1:0]     num;
      logic [SPACING_W-1:0] spacing;
      logic [RSTLEN_W-1:0]  rstlen;
   } cfg_t;

   // A phase lasting len cycles is loaded with len-1 and left on the zero flag;
   // len 0 collapses to a single cycle, which callers only use where that is wanted.
   function automatic logic [CNT_W-1:0] len_to_load(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : len - CNT_W'(1);
   endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable 16-bit down-counter; saturates at zero and flags it combinationally.
module cycle_counter
   import glitch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/glitch_sequencer.sv
// Fault-injection sequencer: optional target reset, delay, then N glitch pulses with spacing.
// All outputs are registered from next-state; config is shadowed when a sequence starts.
module glitch_sequencer
   import glitch_pkg::*;
#(
   parameter logic TARGET_RST_ACTIVE = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DELAY_W-1:0]   delay_i,
   input  logic [WIDTH_W-1:0]   width_i,
   input  logic [NUM_W-1:0]     num_pulses_i,
   input  logic [SPACING_W-1:0] pulse_spacing_i,
   input  logic [RSTLEN_W-1:0]  reset_length_i,
   input  logic                 pulse_en_i,
   input  logic                 reset_en_i,
   input  logic                 abort_i,
   output logic                 glitch_o,
   output logic                 target_rst_o,
   output logic                 busy_o,
   output logic                 done_o
);

   state_e           state_q, state_d;
   cfg_t             shadow_q, shadow_d;
   cfg_t             live_cfg, cfg;
   logic [NUM_W-1:0] pcnt_q, pcnt_d;
   logic             glitch_q, trst_q, busy_q, done_q;

   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_val;

   state_e           run_state, dly_state;
   logic [CNT_W-1:0] run_load, dly_load;

   assign live_cfg = {delay_i, width_i, num_pulses_i, pulse_spacing_i, reset_length_i};

   // In IDLE the live inputs are what gets latched this edge, so decisions use them directly.
   assign cfg = (state_q == ST_IDLE) ? live_cfg : shadow_q;

   cycle_counter u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Where to go once the delay has elapsed, and where to go once a strobe/reset is done.
   always_comb begin
      run_state = ST_PULSE;
      run_load  = len_to_load(CNT_W'(cfg.width));
      if ((cfg.width == '0) || (cfg.num == '0)) begin
         run_state = ST_DONE;
         run_load  = '0;
      end
      dly_state = run_state;
      dly_load  = run_load;
      if (cfg.delay != '0) begin
         dly_state = ST_DELAY;
         dly_load  = len_to_load(cfg.delay);
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      pcnt_d   = pcnt_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (reset_en_i || pulse_en_i) begin
               shadow_d = cfg;
               pcnt_d   = '0;
               cnt_load = 1'b1;
               if (reset_en_i && (cfg.rstlen != '0)) begin
                  state_d = ST_TRST;
                  cnt_val = len_to_load(cfg.rstlen);
               end else begin
                  state_d = dly_state;
                  cnt_val = dly_load;
               end
            end
         end
         ST_TRST: begin
            if (cnt_zero) begin
               state_d  = dly_state;
               cnt_load = 1'b1;
               cnt_val  = dly_load;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_DELAY: begin
            if (cnt_zero) begin
               state_d  = run_state;
               cnt_load = 1'b1;
               cnt_val  = run_load;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_PULSE: begin
            if (cnt_zero) begin
               if (pcnt_q == (cfg.num - NUM_W'(1))) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_SPACE;
                  pcnt_d   = pcnt_q + NUM_W'(1);
                  cnt_load = 1'b1;
                  cnt_val  = len_to_load(cfg.spacing);
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_SPACE: begin
            if (cnt_zero) begin
               state_d  = ST_PULSE;
               cnt_load = 1'b1;
               cnt_val  = run_load;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort beats everything, including a strobe arriving in the same cycle.
      if (abort_i) begin
         state_d  = ST_IDLE;
         shadow_d = shadow_q;
         pcnt_d   = '0;
         cnt_load = 1'b1;
         cnt_val  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         pcnt_q   <= '0;
         glitch_q <= 1'b0;
         trst_q   <= ~TARGET_RST_ACTIVE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         pcnt_q   <= pcnt_d;
         glitch_q <= (state_d == ST_PULSE);
         trst_q   <= (state_d == ST_TRST) ? TARGET_RST_ACTIVE : ~TARGET_RST_ACTIVE;
         busy_q   <= (state_d != ST_IDLE);
         done_q   <= (state_d == ST_DONE);
      end
   end

   assign glitch_o     = glitch_q;
   assign target_rst_o = trst_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule
